// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared types and encodings for the multicycle control FSM
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_R_EXEC,
        S_R_WB,
        S_BRANCH,
        S_JUMP,
        S_ADDI_EXEC,
        S_ADDI_WB
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_LT  = 3'd4
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

endpackage

// File: rtl/multicycle_alu_controller_if.sv
// rtl/multicycle_alu_controller_if.sv - IR fields in, datapath controls out
interface multicycle_alu_controller_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic [2:0] aluControl;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic       iord;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       memToReg;
    logic       regWrite;
    logic [1:0] pcSrc;
    logic       pcEn;
    logic       illegal;

    // controller side
    modport master (
        input  opcode, funct, zero,
        output aluControl, aluSrcA, aluSrcB, iord, memRead, memWrite, irWrite,
               regDst, memToReg, regWrite, pcSrc, pcEn, illegal
    );

    // datapath side
    modport slave (
        output opcode, funct, zero,
        input  aluControl, aluSrcA, aluSrcB, iord, memRead, memWrite, irWrite,
               regDst, memToReg, regWrite, pcSrc, pcEn, illegal
    );
endinterface

// File: rtl/alu_funct_decoder.sv
// rtl/alu_funct_decoder.sv - R-type funct field to ALU operation
module alu_funct_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output alu_op_t    alu_op,
    output logic       illegal_funct
);

    // unknown funct falls back to add so the ALU input is always defined
    always_comb begin
        alu_op        = ALU_ADD;
        illegal_funct = 1'b0;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_LT;
            default: illegal_funct = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_alu_controller.sv
// rtl/multicycle_alu_controller.sv - multicycle MIPS control FSM with memory hold counter
module multicycle_alu_controller
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    multicycle_alu_controller_if.master bus
);

    state_t     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic       wait_last;

    alu_op_t    dec_op;
    logic       dec_illegal;

    alu_op_t    alu_ctl;
    logic       src_a, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, pc_write, pc_write_cond, illegal;
    logic [1:0] src_b, pc_src;

    alu_funct_decoder u_funct_dec (
        .funct         (bus.funct),
        .alu_op        (dec_op),
        .illegal_funct (dec_illegal)
    );

    assign wait_last = (wait_q == 4'(MEM_LAT - 1));

    // state and memory-hold counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // next-state and Moore control decode
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        alu_ctl       = ALU_ADD;
        src_a         = 1'b0;
        src_b         = 2'd0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        pc_src        = 2'd0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        illegal       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                src_b    = 2'd1;
                if (wait_last) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    wait_d   = 4'd0;
                    state_d  = S_DECODE;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_DECODE: begin
                src_b = 2'd3;
                case (bus.opcode)
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                src_a   = 1'b1;
                src_b   = 2'd2;
                state_d = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (wait_last) begin
                    wait_d  = 4'd0;
                    state_d = S_MEM_WB;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (wait_last) begin
                    wait_d  = 4'd0;
                    state_d = S_FETCH;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_R_EXEC: begin
                src_a   = 1'b1;
                alu_ctl = dec_op;
                if (dec_illegal) begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_R_WB;
                end
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                alu_ctl   = dec_op;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                src_a         = 1'b1;
                alu_ctl       = ALU_SUB;
                pc_src        = 2'd1;
                pc_write_cond = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_src   = 2'd2;
                pc_write = 1'b1;
                state_d  = S_FETCH;
            end
            S_ADDI_EXEC: begin
                src_a   = 1'b1;
                src_b   = 2'd2;
                state_d = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                src_a     = 1'b1;
                src_b     = 2'd2;
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // every control is held low while reset is asserted
    assign bus.aluControl = rst ? 3'd0 : alu_ctl;
    assign bus.aluSrcA    = src_a & ~rst;
    assign bus.aluSrcB    = rst ? 2'd0 : src_b;
    assign bus.iord       = iord & ~rst;
    assign bus.memRead    = mem_read & ~rst;
    assign bus.memWrite   = mem_write & ~rst;
    assign bus.irWrite    = ir_write & ~rst;
    assign bus.regDst     = reg_dst & ~rst;
    assign bus.memToReg   = mem_to_reg & ~rst;
    assign bus.regWrite   = reg_write & ~rst;
    assign bus.pcSrc      = rst ? 2'd0 : pc_src;
    assign bus.pcEn       = (pc_write | (pc_write_cond & bus.zero)) & ~rst;
    assign bus.illegal    = illegal & ~rst;

endmodule

// File: tb/tb_multicycle_alu_controller.sv
// tb/tb_multicycle_alu_controller.sv - randomized model-checked bench for the control FSM
module tb_multicycle_alu_controller;
    import mc_ctrl_pkg::*;

    typedef struct packed {
        logic [2:0] alu;
        logic       srca;
        logic [1:0] srcb;
        logic       iord, mrd, mwr, irw, rdst, m2r, rw;
        logic [1:0] pcsrc;
        logic       pcen, ill;
    } ov_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1, rst3;
    multicycle_alu_controller_if if1();
    multicycle_alu_controller_if if3();

    multicycle_alu_controller #(.MEM_LAT(1)) dut1 (.clk(clk), .rst(rst1), .bus(if1.master));
    multicycle_alu_controller #(.MEM_LAT(3)) dut3 (.clk(clk), .rst(rst3), .bus(if3.master));

    ov_t got1, got3;
    assign got1 = {if1.aluControl, if1.aluSrcA, if1.aluSrcB, if1.iord, if1.memRead, if1.memWrite,
                   if1.irWrite, if1.regDst, if1.memToReg, if1.regWrite, if1.pcSrc, if1.pcEn, if1.illegal};
    assign got3 = {if3.aluControl, if3.aluSrcA, if3.aluSrcB, if3.iord, if3.memRead, if3.memWrite,
                   if3.irWrite, if3.regDst, if3.memToReg, if3.regWrite, if3.pcSrc, if3.pcEn, if3.illegal};

    int    checks = 0;
    int    errors = 0;
    ov_t   trace[$];
    ov_t   exp_cur;
    logic  chk_on = 1'b0;
    int    sel = 1;
    int    cyc_idx = 0;
    string cur_name = "";
    logic  prev_ill = 1'b0;

    // ALU code an R-type funct must produce, -1 when the funct is undefined
    function automatic int alu_of(input logic [5:0] fn);
        case (fn)
            6'b100000: return 0;
            6'b100010: return 1;
            6'b100100: return 2;
            6'b100101: return 3;
            6'b101010: return 4;
            default:   return -1;
        endcase
    endfunction

    // per-cycle expected control vectors for one instruction
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z, input int lat);
        ov_t v;
        int  a;
        trace.delete();
        for (int i = 0; i < lat; i++) begin
            v = '0; v.mrd = 1; v.srcb = 2'd1;
            if (i == lat - 1) begin v.irw = 1; v.pcen = 1; end
            trace.push_back(v);
        end
        v = '0; v.srcb = 2'd3;
        v.ill = !(op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000});
        trace.push_back(v);
        if (op == 6'b100011 || op == 6'b101011) begin
            v = '0; v.srca = 1; v.srcb = 2'd2; trace.push_back(v);
            for (int i = 0; i < lat; i++) begin
                v = '0; v.iord = 1;
                if (op == 6'b100011) v.mrd = 1; else v.mwr = 1;
                trace.push_back(v);
            end
            if (op == 6'b100011) begin v = '0; v.rw = 1; v.m2r = 1; trace.push_back(v); end
        end else if (op == 6'b000000) begin
            a = alu_of(fn);
            v = '0; v.srca = 1;
            if (a < 0) begin v.ill = 1; trace.push_back(v); end
            else begin
                v.alu = 3'(a); trace.push_back(v);
                v = '0; v.rw = 1; v.rdst = 1; v.alu = 3'(a); trace.push_back(v);
            end
        end else if (op == 6'b000100) begin
            v = '0; v.srca = 1; v.alu = 3'd1; v.pcsrc = 2'd1; v.pcen = z; trace.push_back(v);
        end else if (op == 6'b000010) begin
            v = '0; v.pcsrc = 2'd2; v.pcen = 1; trace.push_back(v);
        end else if (op == 6'b001000) begin
            v = '0; v.srca = 1; v.srcb = 2'd2; trace.push_back(v);
            v.rw = 1; trace.push_back(v);
        end
    endtask

    task automatic pin(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, expv);
        end
    endtask

    task automatic drive(input int which, input logic [5:0] op, input logic [5:0] fn, input logic z);
        if (which == 1) begin if1.opcode = op; if1.funct = fn; if1.zero = z; end
        else begin if3.opcode = op; if3.funct = fn; if3.zero = z; end
    endtask

    // replay the model trace against the chosen DUT, one vector per cycle
    task automatic run(input int which, input string name, input logic [5:0] op,
                       input logic [5:0] fn, input logic z);
        build(op, fn, z, (which == 1) ? 1 : 3);
        drive(which, op, fn, z);
        sel = which;
        cur_name = name;
        for (int i = 0; i < trace.size(); i++) begin
            cyc_idx = i;
            exp_cur = trace[i];
            chk_on  = 1'b1;
            @(posedge clk); #1;
        end
        chk_on = 1'b0;
    endtask

    // single compare process: model vector and invariants on every checked cycle
    always @(negedge clk) begin
        ov_t g;
        if (chk_on) begin
            g = (sel == 1) ? got1 : got3;
            checks++;
            if (g !== exp_cur) begin
                errors++;
                $display("FAIL %s cycle %0d got %h expected %h", cur_name, cyc_idx, g, exp_cur);
            end
            checks++;
            if ((g.mrd && g.mwr) || (g.rw && g.mwr) || (g.ill && prev_ill)) begin
                errors++;
                $display("FAIL invariant %s cycle %0d got %h expected no conflict", cur_name, cyc_idx, g);
            end
            prev_ill = g.ill;
        end else begin
            prev_ill = 1'b0;
        end
    end

    int mr_cnt, mw_cnt;

    initial begin
        logic [5:0] op, fn;
        logic       z;
        rst1 = 1'b1; rst3 = 1'b1;
        drive(1, 6'b100011, 6'd0, 1'b0);
        drive(3, 6'b100011, 6'd0, 1'b0);

        // reset: all outputs low
        sel = 1; cur_name = "reset"; exp_cur = '0;
        for (int i = 0; i < 2; i++) begin cyc_idx = i; chk_on = 1; @(posedge clk); #1; end
        chk_on = 0;
        rst1 = 1'b0;

        // model pins: cycle counts and key fields
        build(6'b100011, 6'd0, 0, 1); pin("lw_len", trace.size(), 5);
        build(6'b101011, 6'd0, 0, 1); pin("sw_len", trace.size(), 4);
        build(6'b000000, 6'b100010, 0, 1); pin("rsub_len", trace.size(), 4); pin("rsub_alu", int'(trace[2].alu), 1);
        pin("rsub_wb", int'({trace[3].rw, trace[3].rdst}), 3);
        build(6'b000000, 6'b101010, 0, 1); pin("slt_alu", int'(trace[2].alu), 4);
        build(6'b001000, 6'd0, 0, 1); pin("addi_len", trace.size(), 4); pin("addi_srcb", int'(trace[3].srcb), 2);
        build(6'b000100, 6'd0, 1, 1); pin("beq_len", trace.size(), 3); pin("beq_pcen", int'(trace[2].pcen), 1);
        build(6'b000010, 6'd0, 0, 1); pin("j_len", trace.size(), 3); pin("j_pcsrc", int'(trace[2].pcsrc), 2);
        build(6'b111111, 6'd0, 0, 1); pin("ill_len", trace.size(), 2); pin("ill_flag", int'(trace[1].ill), 1);
        build(6'b000000, 6'b000111, 0, 1); pin("illfn_len", trace.size(), 3);
        build(6'b100011, 6'd0, 0, 3); pin("lw3_len", trace.size(), 9);
        mr_cnt = 0; foreach (trace[i]) mr_cnt += int'(trace[i].mrd);
        pin("lw3_memread", mr_cnt, 6);
        build(6'b101011, 6'd0, 0, 3); pin("sw3_len", trace.size(), 8);
        mw_cnt = 0; foreach (trace[i]) mw_cnt += int'(trace[i].mwr);
        pin("sw3_memwrite", mw_cnt, 3);

        // directed sequence, MEM_LAT=1
        run(1, "rsub", 6'b000000, 6'b100010, 0);
        run(1, "slt", 6'b000000, 6'b101010, 0);
        run(1, "addi", 6'b001000, 6'd0, 0);
        run(1, "j", 6'b000010, 6'd0, 0);
        run(1, "beq_taken", 6'b000100, 6'd0, 1);
        run(1, "beq_not", 6'b000100, 6'd0, 0);
        run(1, "ill_op", 6'b111111, 6'd0, 0);
        run(1, "ill_fn", 6'b000000, 6'b000111, 0);

        // reset held two cycles during MEM_WB of a lw
        build(6'b100011, 6'd0, 0, 1);
        drive(1, 6'b100011, 6'd0, 0);
        sel = 1; cur_name = "lw_pre_reset";
        for (int i = 0; i < 4; i++) begin cyc_idx = i; exp_cur = trace[i]; chk_on = 1; @(posedge clk); #1; end
        rst1 = 1'b1; cur_name = "reset_mid_lw"; exp_cur = '0;
        for (int i = 0; i < 2; i++) begin cyc_idx = i; @(posedge clk); #1; end
        chk_on = 0;
        rst1 = 1'b0;
        run(1, "after_reset", 6'b000000, 6'b100000, 0);

        // randomized instruction stream, MEM_LAT=1
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 6))
                0: op = 6'b000000; 1: op = 6'b100011; 2: op = 6'b101011; 3: op = 6'b000100;
                4: op = 6'b000010; 5: op = 6'b001000; default: op = 6'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0: fn = 6'b100000; 1: fn = 6'b100010; 2: fn = 6'b100100; 3: fn = 6'b100101;
                4: fn = 6'b101010; default: fn = 6'($urandom);
            endcase
            z = 1'($urandom);
            run(1, "rand1", op, fn, z);
        end

        // MEM_LAT=3 instance
        rst1 = 1'b1;
        @(posedge clk); #1;
        rst3 = 1'b0;
        run(3, "lw3", 6'b100011, 6'd0, 0);
        run(3, "sw3", 6'b101011, 6'd0, 0);
        run(3, "beq3", 6'b000100, 6'd0, 1);
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 6))
                0: op = 6'b000000; 1: op = 6'b100011; 2: op = 6'b101011; 3: op = 6'b000100;
                4: op = 6'b000010; 5: op = 6'b001000; default: op = 6'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0: fn = 6'b100000; 1: fn = 6'b100010; 2: fn = 6'b100100; 3: fn = 6'b100101;
                4: fn = 6'b101010; default: fn = 6'($urandom);
            endcase
            z = 1'($urandom);
            run(3, "rand3", op, fn, z);
        end

        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
